// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder slice.
//   state_t    : responder FSM states (IDLE / WAIT / RESP)
//   LAT_CNT_W  : width of the latency down-counter (covers LATENCY 1..15)
//   idx_width  : number of word-index bits needed to address DEPTH words
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LAT_CNT_W = 4;

    // Ceiling log2 with a floor of one bit so a single-word memory still has an index.
    function automatic int idx_width(input int depth);
        int w;
        w = 1;
        while ((32'sd1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Request/response bundle between the MEM-stage requester and the responder.
//   req_valid/req_ready : request handshake
//   req_we/addr/wdata/wstrb : request payload (store flag, byte address, data, byte enables)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : response payload
// Modports: master = requester side, slave = responder side.
// -----------------------------------------------------------------------------
interface dmem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_wstrb;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_sram_array.sv
// -----------------------------------------------------------------------------
// dmem_sram_array
// DEPTH x DATA_WIDTH word storage, synchronous byte-masked write, asynchronous read.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   idx   : word index for both read and write
//   wdata : write data
//   wmask : per-byte write enable
//   rdata : combinational read data at idx
// -----------------------------------------------------------------------------
module dmem_sram_array #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Byte-masked write port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wmask[b]) begin
                    mem_r[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory target. Accepts a load/store over bus, performs it
// on the internal SRAM at the accept edge, and presents the response LATENCY cycles
// later, holding it until the requester consumes it.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dmem_if.slave (request and response channels)
// Optional feature: DMEM_STRB_EN -- when defined, stores honour req_wstrb byte
// enables; otherwise every store writes the full word.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam int IDX_W  = idx_width(DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;
    // One extra bit so DEPTH*4 is representable even when it equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);

    state_t                  state_r;
    logic [LAT_CNT_W-1:0]    cnt_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_err_r;

    logic                    accept_s;
    logic                    err_s;
    logic                    sram_we_s;
    logic [IDX_W-1:0]        idx_s;
    logic [STRB_W-1:0]       wmask_s;
    logic [DATA_WIDTH-1:0]   sram_rdata_s;
    logic [DATA_WIDTH-1:0]   load_data_s;

    assign accept_s  = (state_r == IDLE) && req_ready_r && bus.req_valid;
    assign idx_s     = bus.req_addr[IDX_W+1:2];
    assign sram_we_s = accept_s && bus.req_we && !err_s;

    // Misaligned or beyond the last word: the access is refused but still answered.
    always_comb begin
        err_s = 1'b0;
        if (bus.req_addr[1:0] != 2'b00) begin
            err_s = 1'b1;
        end else if ({1'b0, bus.req_addr} >= ADDR_LIMIT) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

`ifdef DMEM_STRB_EN
    assign wmask_s = bus.req_wstrb;
`else
    logic unused_wstrb_s;
    assign unused_wstrb_s = ^bus.req_wstrb;
    assign wmask_s        = {STRB_W{1'b1}};
`endif

    // Stores and faulted accesses return zero data; loads return the addressed word.
    always_comb begin
        load_data_s = {DATA_WIDTH{1'b0}};
        if (bus.req_we || err_s) begin
            load_data_s = {DATA_WIDTH{1'b0}};
        end else begin
            load_data_s = sram_rdata_s;
        end
    end

    dmem_sram_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we_s),
        .idx   (idx_s),
        .wdata (bus.req_wdata),
        .wmask (wmask_s),
        .rdata (sram_rdata_s)
    );

    // Responder FSM: latency countdown, response registers and ready generation.
    // RESP spends its first cycle raising rsp_valid, so entering RESP one edge
    // early is what makes rsp_valid appear exactly LATENCY edges after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {LAT_CNT_W{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        req_ready_r <= 1'b0;
                        rsp_err_r   <= err_s;
                        rsp_rdata_r <= load_data_s;
                        if (LATENCY == 32'sd1) begin
                            state_r <= RESP;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= LAT_CNT_W'(LATENCY - 1);
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - LAT_CNT_W'(1);
                    if (cnt_r == LAT_CNT_W'(1)) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    if (!rsp_valid_r) begin
                        rsp_valid_r <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule
